// File: rtl/conv_pkg.sv
// Shared definitions for the convolution load/run sequencer: FSM encoding and buffer depths.
package conv_pkg;

  localparam int KW3_DEPTH_C  = 9;
  localparam int KW5_DEPTH_C  = 25;
  localparam int IFMD_DEPTH_C = 64;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_KW_WR   = 3'd1;
  localparam logic [2:0] ST_IFMD_WR = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    KW_WR   = ST_KW_WR,
    IFMD_WR = ST_IFMD_WR,
    START   = ST_START,
    RUN     = ST_RUN
  } state_e;

endpackage

// File: rtl/beat_addr_cnt.sv
// Beat-driven write address counter with a run-time terminal index; shared by both load phases.
module beat_addr_cnt #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] limit,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  last
);

  assign last = (cnt == limit);

  // Clear wins over increment; holding at the limit keeps the count inside the phase.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_load_ctrl.sv
// Load/run sequencer: streams kernel then feature-map words into memory, launches the core, reports done.
module conv_load_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KW3_DEPTH  = KW3_DEPTH_C,
  parameter int KW5_DEPTH  = KW5_DEPTH_C,
  parameter int IFMD_DEPTH = IFMD_DEPTH_C,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_st,
  input  logic                  is_5x5,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  kw_we,
  output logic                  ifmd_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mode_5x5,
  output logic                  conv_start,
  input  logic                  conv_done,
  output logic                  busy,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic                    mode_q;
  logic                    done_q;
  logic                    cnt_clr;
  logic                    cnt_inc;
  logic                    cnt_last;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   limit;

  beat_addr_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .limit(limit),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // A beat only exists in the write states, so either write enable marks one.
  assign cnt_inc = kw_we | ifmd_we;

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    kw_we      = 1'b0;
    ifmd_we    = 1'b0;
    conv_start = 1'b0;
    cnt_clr    = 1'b0;
    limit      = ADDR_WIDTH'(IFMD_DEPTH - 1);
    case (state_q)
      IDLE: begin
        if (in_st) begin
          cnt_clr = 1'b1;
          state_d = KW_WR;
        end
      end
      KW_WR: begin
        in_ready = 1'b1;
        kw_we    = in_valid;
        limit    = mode_q ? ADDR_WIDTH'(KW5_DEPTH - 1) : ADDR_WIDTH'(KW3_DEPTH - 1);
        if (in_valid && cnt_last) begin
          cnt_clr = 1'b1;
          state_d = IFMD_WR;
        end
      end
      IFMD_WR: begin
        in_ready = 1'b1;
        ifmd_we  = in_valid;
        if (in_valid && cnt_last) begin
          cnt_clr = 1'b1;
          state_d = START;
        end
      end
      START: begin
        conv_start = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (conv_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == RUN) && conv_done;
      if (state_q == IDLE && in_st) begin
        mode_q <= is_5x5;
      end
    end
  end

  assign wr_addr  = cnt;
  assign wr_data  = in_data;
  assign mode_5x5 = mode_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_conv_load_ctrl.sv
// Directed bench for conv_load_ctrl: load sequencing, timing, backpressure gaps, ignored commands, reset.
module tb_conv_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_st;
  logic       is_5x5;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       kw_we;
  logic       ifmd_we;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       mode_5x5;
  logic       conv_start;
  logic       conv_done;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc;

  // Load statistics filled by run_load
  int kw_n, if_n, kw_bad, if_bad, kw_last, if_first, data_bad;
  int noval, mode_bad, done_early, idle_cyc, start_cyc;

  conv_load_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_st     (in_st),
    .is_5x5    (is_5x5),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .kw_we     (kw_we),
    .ifmd_we   (ifmd_we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mode_5x5  (mode_5x5),
    .conv_start(conv_start),
    .conv_done (conv_done),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; in_st = 1'b0; is_5x5 = 1'b0; in_valid = 1'b0; in_data = '0; conv_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Issues in_st in cycle 0 and streams words until conv_start is seen (bounded).
  task automatic run_load(input bit m5, input int gap_pct, input bit disturb);
    int kdepth;
    kdepth = m5 ? 25 : 9;
    kw_n = 0; if_n = 0; kw_bad = 0; if_bad = 0; kw_last = -1; if_first = -1; data_bad = 0;
    noval = 0; mode_bad = 0; done_early = 0; idle_cyc = 0; start_cyc = -1;
    @(negedge clk);
    cyc = 0; in_st = 1'b1; is_5x5 = m5; in_valid = 1'b0; conv_done = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      cyc       = c;
      in_st     = disturb && (c % 7 == 0);
      is_5x5    = disturb ? ~m5 : m5;
      in_valid  = ($urandom_range(99) >= gap_pct);
      in_data   = 8'(((kw_n < kdepth) ? kw_n : if_n) + 1);
      conv_done = disturb && (kw_n == 3);
      #1;
      if ((kw_we || ifmd_we) && !in_valid) noval++;
      if (mode_5x5 !== m5) mode_bad++;
      if (done) done_early++;
      if (in_ready && !in_valid) idle_cyc++;
      if (kw_we) begin
        if (wr_addr !== 6'(kw_n) || if_n != 0) kw_bad++;
        if (wr_data !== in_data) data_bad++;
        kw_last = int'(wr_addr);
        kw_n++;
      end
      if (ifmd_we) begin
        if (wr_addr !== 6'(if_n) || kw_n != kdepth) if_bad++;
        if (wr_data !== in_data) data_bad++;
        if (if_first < 0) if_first = c;
        if_n++;
      end
      if (conv_start) begin
        start_cyc = c;
        break;
      end
    end
    in_st = 1'b0; in_valid = 1'b0; conv_done = 1'b0; is_5x5 = m5;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_st = 1'b0; is_5x5 = 1'b0; in_valid = 1'b1; in_data = 8'h5a; conv_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, kw_we, ifmd_we, conv_start, busy, done, mode_5x5} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {in_ready, kw_we, ifmd_we, conv_start, busy, done, mode_5x5});
    end
    checks++;
    if (wr_addr !== 6'd0) begin
      errors++; $display("FAIL reset_addr: got %0d want 0", wr_addr);
    end
    in_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_3x3();
    run_load(1'b0, 0, 1'b0);
    checks++; if (start_cyc != 74) begin errors++; $display("FAIL 3x3_start_cycle: got %0d want 74", start_cyc); end
    checks++; if (kw_n != 9 || kw_last != 8) begin errors++; $display("FAIL 3x3_kw: got n=%0d last=%0d want n=9 last=8", kw_n, kw_last); end
    checks++; if (if_n != 64 || if_first != 10) begin errors++; $display("FAIL 3x3_ifmd: got n=%0d first=%0d want n=64 first=10", if_n, if_first); end
    checks++; if (kw_bad + if_bad + data_bad != 0) begin errors++; $display("FAIL 3x3_addr_data: got %0d/%0d/%0d bad want 0", kw_bad, if_bad, data_bad); end
    checks++; if (done_early != 0 || mode_bad != 0) begin errors++; $display("FAIL 3x3_done_mode: got %0d/%0d want 0/0", done_early, mode_bad); end
    while (cyc < 80) begin
      @(negedge clk);
      cyc++;
      conv_done = (cyc == 80);
      #1;
      if (cyc == 75) begin
        checks++;
        if (conv_start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
          errors++; $display("FAIL 3x3_run_entry: got start=%b busy=%b rdy=%b want 0 1 0", conv_start, busy, in_ready);
        end
      end
    end
    @(negedge clk);
    cyc++; conv_done = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL 3x3_done_81: got done=%b busy=%b want 1 0", done, busy); end
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL 3x3_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_5x5();
    run_load(1'b1, 0, 1'b0);
    checks++; if (start_cyc != 90) begin errors++; $display("FAIL 5x5_start_cycle: got %0d want 90", start_cyc); end
    checks++; if (kw_n != 25 || kw_last != 24) begin errors++; $display("FAIL 5x5_kw: got n=%0d last=%0d want n=25 last=24", kw_n, kw_last); end
    checks++; if (if_n != 64 || if_first != 26 || if_bad != 0 || kw_bad != 0) begin
      errors++; $display("FAIL 5x5_ifmd: got n=%0d first=%0d bad=%0d/%0d want 64 26 0 0", if_n, if_first, kw_bad, if_bad);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_st = (i % 2 == 0); is_5x5 = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || mode_5x5 !== 1'b1 || kw_we !== 1'b0) begin
        errors++; $display("FAIL 5x5_run_hold: got busy=%b rdy=%b mode=%b kw_we=%b want 1 0 1 0", busy, in_ready, mode_5x5, kw_we);
      end
    end
    @(negedge clk); in_st = 1'b0; conv_done = 1'b1;
    @(negedge clk); conv_done = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL 5x5_done: got %b want 1", done); end
  endtask

  task automatic test_gaps();
    run_load(1'b0, 30, 1'b0);
    checks++; if (kw_n != 9 || if_n != 64) begin errors++; $display("FAIL gaps_count: got %0d+%0d want 9+64", kw_n, if_n); end
    checks++; if (kw_bad != 0 || if_bad != 0 || data_bad != 0) begin errors++; $display("FAIL gaps_addr: got %0d/%0d/%0d bad want 0", kw_bad, if_bad, data_bad); end
    checks++; if (noval != 0) begin errors++; $display("FAIL gaps_we_no_valid: got %0d want 0", noval); end
    checks++; if (start_cyc != 74 + idle_cyc) begin errors++; $display("FAIL gaps_start_cycle: got %0d want %0d", start_cyc, 74 + idle_cyc); end
    @(negedge clk); conv_done = 1'b1;
    @(negedge clk); conv_done = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL gaps_done: got done=%b busy=%b want 1 0", done, busy); end
  endtask

  task automatic test_ignore();
    run_load(1'b0, 20, 1'b1);
    checks++; if (done_early != 0) begin errors++; $display("FAIL ignore_conv_done: got %0d done pulses want 0", done_early); end
    checks++; if (mode_bad != 0) begin errors++; $display("FAIL ignore_mode: got %0d mode changes want 0", mode_bad); end
    checks++; if (kw_n != 9 || if_n != 64 || kw_bad != 0 || if_bad != 0) begin
      errors++; $display("FAIL ignore_writes: got %0d+%0d bad=%0d/%0d want 9+64 0 0", kw_n, if_n, kw_bad, if_bad);
    end
    @(negedge clk); conv_done = 1'b1;
    @(negedge clk); conv_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_load(1'b1, 0, 1'b0);
    @(negedge clk); conv_done = 1'b1;
    @(negedge clk); conv_done = 1'b0; in_st = 1'b1; is_5x5 = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done: got done=%b busy=%b want 1 0", done, busy); end
    @(negedge clk); in_st = 1'b0; in_valid = 1'b1; in_data = 8'd1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || kw_we !== 1'b1 || wr_addr !== 6'd0 || mode_5x5 !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: got rdy=%b we=%b addr=%0d mode=%b want 1 1 0 0", in_ready, kw_we, wr_addr, mode_5x5);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk); in_st = 1'b1; is_5x5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_st = 1'b0; in_valid = 1'b1; in_data = 8'(i + 1);
    end
    @(negedge clk); rst = 1'b0; in_data = 8'd6;
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, kw_we, ifmd_we, conv_start, busy, done, mode_5x5} !== 7'b0) begin
      errors++; $display("FAIL midreset_ctrl: got %b want 0000000",
                         {in_ready, kw_we, ifmd_we, conv_start, busy, done, mode_5x5});
    end
    checks++; if (wr_addr !== 6'd0) begin errors++; $display("FAIL midreset_addr: got %0d want 0", wr_addr); end
    in_st = 1'b1; is_5x5 = 1'b0;
    @(negedge clk); in_st = 1'b0; in_data = 8'd1;
    #1;
    checks++; if (kw_we !== 1'b1 || wr_addr !== 6'd0) begin errors++; $display("FAIL midreset_restart: got we=%b addr=%0d want 1 0", kw_we, wr_addr); end
    @(negedge clk);
    #1;
    checks++; if (wr_addr !== 6'd1) begin errors++; $display("FAIL midreset_advance: got %0d want 1", wr_addr); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_3x3();
    test_5x5();
    test_gaps();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
